mux_nx1_serializer: RTL

- Parametrised N-lane to 1-lane word serializer: captures LANES parallel words (data plus valid) once per frame and emits them one per clock on a single serial lane.
- Sits between the parallel lane logic and the downstream serial/encoding stage.
- Successor of the fixed 2-lane, 8-bit, two-clock mux. Single clock, internal round-robin slot counter, selectable lane order, enable/stall, frame markers.

---
 rtl/mux_nx1_serializer.sv | 85 ++++++++
 1 files changed

// File: rtl/mux_nx1_serializer.sv
// LANES-to-1 word serializer: captures one frame of {data, valid} per LANES enabled
// cycles and emits it slot by slot. Define MUX_NX1_PARITY_EN to add the parity_out port.
module mux_nx1_serializer #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned LANES        = 4,
  parameter int unsigned ORDER        = 0,
  parameter int unsigned ZERO_INVALID = 0,
  localparam int unsigned LW          = (LANES > 2) ? $clog2(LANES) : 1
) (
  input  logic                    clk_4f,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [LANES*DATA_W-1:0] data_in,
  input  logic [LANES-1:0]        valid_in,
  output logic                    load_stb,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic [LW-1:0]           lane_out,
`ifdef MUX_NX1_PARITY_EN
  output logic                    parity_out,
`endif
  output logic                    frame_out
);

  localparam logic [LW-1:0] LAST = LW'(LANES - 1);

  logic [LW-1:0]     cnt;
  logic [LW-1:0]     sel;
  logic [DATA_W-1:0] buf_data [LANES];
  logic [LANES-1:0]  buf_valid;
  logic [DATA_W-1:0] data_next;
  logic              valid_next;

  always_comb begin
    sel        = (ORDER != 0) ? LAST - cnt : cnt;
    valid_next = buf_valid[sel];
    data_next  = buf_data[sel];
    if (ZERO_INVALID != 0 && !valid_next) begin
      data_next = '0;
    end
  end

  // Strobe depends only on registered cnt and enable, so it is stable across the cycle.
  assign load_stb = enable && (cnt == LAST);

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      cnt       <= '0;
      buf_valid <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        buf_data[k] <= '0;
      end
      data_out  <= '0;
      valid_out <= 1'b0;
      lane_out  <= '0;
      frame_out <= 1'b0;
`ifdef MUX_NX1_PARITY_EN
      parity_out <= 1'b0;
`endif
    end else if (enable) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      // The last slot of the old frame is read in the same edge that overwrites the buffer.
      if (cnt == LAST) begin
        for (int unsigned k = 0; k < LANES; k++) begin
          buf_data[k] <= data_in[k*DATA_W +: DATA_W];
        end
        buf_valid <= valid_in;
      end
      data_out  <= data_next;
      valid_out <= valid_next;
      lane_out  <= sel;
      frame_out <= (cnt == '0);
`ifdef MUX_NX1_PARITY_EN
      parity_out <= ^{data_next, valid_next};
`endif
    end else begin
      valid_out <= 1'b0;
      frame_out <= 1'b0;
`ifdef MUX_NX1_PARITY_EN
      parity_out <= ^data_out;
`endif
    end
  end

endmodule
